fetch_sequencer: RTL and testbench

//  Drives the PC of the combinational-read instruction memory and streams fetched words
//  to decode over a valid/ready handshake. Sequences PC from RESET_PC to an end address,

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_out_reg.sv | 47 ++++
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and default parameters for the instruction fetch sequencer.
//   - fetch_state_t : 2-bit FSM state encoding (IDLE/FETCH/DRAIN/DONE)
//   - *_DEF         : default widths and reset PC used by fetch_sequencer
package fetch_pkg;

    localparam int PC_W_DEF     = 10;
    localparam int INSTR_W_DEF  = 32;
    localparam int RESET_PC_DEF = 0;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg
//   Single-entry valid/ready holding register between the fetch FSM and decode.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     load                 capture in_instr/in_pc and raise out_valid
//     flush                drop the held word (wins over load)
//     in_instr, in_pc      word and address to capture
//     out_ready            downstream accept
//     out_valid/instr/pc   held word presented to decode
//   The data fields are only written on load, so out_instr/out_pc stay stable
//   while a word waits for out_ready.
module fetch_out_reg
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (out_ready) begin
            // accepted with nothing new to replace it
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Drives the PC of a combinational-read instruction memory and streams the
//   fetched words to decode over valid/ready. Runs from RESET_PC up to the
//   end address sampled on start, follows branch/jump redirects and kills the
//   in-flight word when one arrives.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   FETCH | issuing one word per cycle while the output slot is free
//   DRAIN | end address issued, waiting for decode to take the last word
//   DONE  | run complete, waiting for the next start
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     start, end_pc     begin a run at RESET_PC; end_pc is the last address
//     imem_pc           address to instruction memory (pc register)
//     imem_instr        instruction memory data for imem_pc, same cycle
//     redirect_valid/pc branch/jump target (FETCH/DRAIN only)
//     out_valid/instr/pc, out_ready   fetched-word handshake to decode
//     busy, done        status (FETCH|DRAIN, DONE)
//     issue_count       words loaded into the output register this run
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    end_pc,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   issue_count
);

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    fetch_state_t      state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic [PC_W-1:0]   end_reg, end_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              load;
    logic              flush;
    logic              slot_free;

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC_V;
            end_reg     <= '0;
            issue_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            end_reg     <= end_nxt;
            issue_count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        end_nxt   = end_reg;
        cnt_nxt   = issue_count;
        load      = 1'b0;
        flush     = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                // redirect is ignored here, so start alone decides
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = RESET_PC_V;
                    end_nxt   = end_pc;
                    cnt_nxt   = '0;
                    flush     = 1'b1;
                end
            end

            ST_FETCH: begin
                if (redirect_valid) begin
                    // kills the held word even if decode accepts it this cycle
                    flush  = 1'b1;
                    pc_nxt = redirect_pc;
                end else if (slot_free) begin
                    load = 1'b1;
                    if (issue_count != '1) begin
                        cnt_nxt = issue_count + 1'b1;
                    end
                    if (pc == end_reg) begin
                        // pc parks on the last address
                        state_nxt = ST_DRAIN;
                    end else begin
                        pc_nxt = pc + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (redirect_valid) begin
                    flush     = 1'b1;
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_FETCH;
                end else if (slot_free) begin
                    flush     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    fetch_out_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .in_instr  (imem_instr),
        .in_pc     (pc),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

    assign imem_pc = pc;
    assign busy    = (state == ST_FETCH) || (state == ST_DRAIN);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [PC_W-1:0]    end_pc;
    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   issue_count;

    logic [INSTR_W-1:0] mem [1024];
    logic [PC_W+INSTR_W-1:0] exp_q [$];

    int total;
    int bad;

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .end_pc         (end_pc),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .issue_count    (issue_count)
    );

    assign imem_instr = mem[imem_pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] word_at(input int a);
        return 32'h1357_0000 + 32'(a * 3 + 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int a);
        exp_q.push_back({PC_W'(a), word_at(a)});
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_start(input int e);
        start  = 1'b1;
        end_pc = PC_W'(e);
        step();
        start  = 1'b0;
    endtask

    // scoreboard monitor: every accepted word must match the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(out_pc), 32'hFFFF_FFFF);
            end else begin
                logic [PC_W+INSTR_W-1:0] e;
                e = exp_q.pop_front();
                chk("acc_pc", 32'(out_pc), 32'(e[PC_W+INSTR_W-1:INSTR_W]));
                chk("acc_instr", out_instr, e[INSTR_W-1:0]);
            end
        end
    end

    initial begin
        int cyc;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = word_at(i);

        rst_n          = 1'b0;
        start          = 1'b0;
        end_pc         = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #22;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_imem_pc", 32'(imem_pc), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(issue_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: straight run 0..5 with decode always ready
        out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) push_exp(i);
        do_start(5);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("t1_cycles", 32'(cyc), 32'd7);
        chk("t1_count", 32'(issue_count), 32'd6);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_out_valid", 32'(out_valid), 32'd0);

        // 2: decode stalls while word 1 is held
        for (int i = 0; i <= 5; i++) push_exp(i);
        do_start(5);
        step();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_pc", 32'(out_pc), 32'd1);
            chk("t2_hold_instr", out_instr, word_at(1));
            chk("t2_hold_imem_pc", 32'(imem_pc), 32'd2);
        end
        out_ready = 1'b1;
        wait_done(cyc);
        chk("t2_count", 32'(issue_count), 32'd6);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: redirect to 4 while word 1 is on the output
        push_exp(0);
        push_exp(4);
        push_exp(5);
        do_start(5);
        step();
        step();
        chk("t3_pre_pc", 32'(out_pc), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 10'd4;
        step();
        redirect_valid = 1'b0;
        chk("t3_killed", 32'(out_valid), 32'd0);
        chk("t3_imem_pc", 32'(imem_pc), 32'd4);
        wait_done(cyc);
        chk("t3_count", 32'(issue_count), 32'd4);
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: end_pc = 0, single word, then rerun
        push_exp(0);
        do_start(0);
        step();
        chk("t4_drain_busy", 32'(busy), 32'd1);
        chk("t4_drain_pc", 32'(imem_pc), 32'd0);
        wait_done(cyc);
        chk("t4_cycles", 32'(cyc), 32'd1);
        chk("t4_count", 32'(issue_count), 32'd1);
        push_exp(0);
        do_start(0);
        wait_done(cyc);
        chk("t4b_count", 32'(issue_count), 32'd1);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset while a word is held in FETCH
        out_ready = 1'b0;
        do_start(5);
        step();
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_imem_pc", 32'(imem_pc), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_count", 32'(issue_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t5_idle_busy", 32'(busy), 32'd0);

        // 6: wrap-around 1023 -> 0 -> 1
        out_ready = 1'b1;
        push_exp(1023);
        push_exp(0);
        push_exp(1);
        do_start(1);
        redirect_valid = 1'b1;
        redirect_pc    = 10'd1023;
        step();
        redirect_valid = 1'b0;
        chk("t6_imem_pc", 32'(imem_pc), 32'd1023);
        wait_done(cyc);
        chk("t6_count", 32'(issue_count), 32'd3);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        // redirect in DONE is ignored
        redirect_valid = 1'b1;
        redirect_pc    = 10'd7;
        step();
        redirect_valid = 1'b0;
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_imem_pc", 32'(imem_pc), 32'd1);

        // start and redirect together in DONE: start wins
        push_exp(0);
        start          = 1'b1;
        end_pc         = 10'd0;
        redirect_valid = 1'b1;
        redirect_pc    = 10'd9;
        step();
        start          = 1'b0;
        redirect_valid = 1'b0;
        chk("t8_imem_pc", 32'(imem_pc), 32'd0);
        chk("t8_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("t8_count", 32'(issue_count), 32'd1);
        chk("t8_q_empty", 32'(exp_q.size()), 32'd0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
